discrete_values_table_loader: RTL and testbench
===============================================

Name: discrete_values_table_loader

Overview:
- Write-side companion of the discrete values table: converts a word stream from the host/config interface into table write transactions.
- Each transaction writes one {start,end} range for a (variable index, choice index) address.
- Replaces the static memory-file image with runtime programming.
- Sits between the configuration stream source and the table's write port.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 8, width W of start/end values and of stream words.
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 8, width V of variable index; V <= W required.
- MAX_BIT_WIDTH_OF_DISCRETE_CHOICES, 4, width C of choice index (up to 2^C choices per variable); C <= W required.

Ports:
- in_clock  input  1  single clock, rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_start  input  1  one-cycle pulse; opens a load session when idle.
- in_data  input  W  stream word.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final word of the session.
- out_ready  output  1  loader accepts a word this cycle.
- out_write_enable  output  1  table write strobe.
- out_write_address  output  V+C  {variable index, choice index}.
- out_write_data  output  2W  {start, end}; start in the upper W bits.
- out_busy  output  1  session active.
- out_done  output  1  one-cycle pulse on clean session end.
- out_error  output  1  sticky error flag; cleared by in_start.
- out_entries_written  output  V+C+1  writes issued this session.

Behaviour:
- Reset (async, in_reset_n=0): state IDLE; all outputs 0; internal registers 0. Applies immediately, including mid-record; no write is issued for a partial record.
- Handshake: a word is accepted at a rising edge when in_valid && out_ready. in_valid gaps are allowed; the FSM holds its state.
- out_ready is 1 in VAR, COUNT, START and END states, and 0 in IDLE.
- Record format, in order:
  - VAR word: low V bits = variable index.
  - COUNT word: low C bits = number of choices minus 1.
  - Then choices+1 pairs of START word and END word.
  - Upper unused bits of VAR and COUNT words are ignored.
- FSM transitions:
  - IDLE -> VAR on in_start. Same edge: clear out_error and out_entries_written; out_busy goes to 1.
  - VAR -> COUNT on accept.
  - COUNT -> START on accept; choice counter reset to 0.
  - START -> END on accept; start word latched.
  - END, on accept:
    - If the choice counter is not yet at the count: increment it, go to START.
    - Otherwise: go to VAR, or to IDLE if in_last=1.
- Write generation (registered): an accepted END word at edge k drives out_write_enable=1 for exactly one cycle after k, with address {var, choice} and data {start, end}.
  - out_entries_written increments at the same edge.
  - Address and data hold their last values when the strobe is 0.
- Range check: if start > end (unsigned), no write is issued and out_error is set. The session continues.
- Clean end: in_last accepted on the final END word of a record -> IDLE. out_done=1 for one cycle after that edge, coincident with that record's write strobe. out_busy=0 from the same cycle.
- Protocol error: in_last accepted on any VAR, COUNT or START word, or on a non-final END word.
  - out_error is set; FSM goes to IDLE; out_done is not pulsed.
  - A write for that END word is still issued if it is a valid range.
- in_start while busy is ignored. in_start in IDLE clears out_error.
- Rewriting the same address later in a session is allowed; the last write wins.
- out_entries_written saturates at 2^(V+C), which is the full table.

Test Plan:
- Single record: start; words 3, 0, 10, 20 (in_last on the 20) -> one strobe, address 0x030, data 0x0A14; out_done pulse with the strobe; out_entries_written=1; out_error=0.
- Two records: var 1 with pairs (5,5),(7,9); then var 255, count 15, pairs (i,i+1) for i=0..15, in_last on the final word -> addresses 0x010, 0x011, 0xFF0..0xFFF; out_entries_written=18; one out_done.
- Bad range: var 2, count 0, pair (30,10), last -> no strobe; out_error=1; out_done pulses; out_entries_written=0. A new in_start then clears out_error.
- Early in_last on a START word -> out_error=1; no out_done; FSM in IDLE; out_ready=0. Words sent while idle are not accepted.
- Random in_valid gaps during a 4-choice record -> writes identical to the gap-free run; each strobe exactly one cycle wide.
- in_reset_n pulsed low after the START word -> outputs zero immediately; no strobe follows. The next session loads var 4, (1,2) correctly to address 0x040. An in_start pulse mid-session is ignored.

Source files
------------

// File: rtl/discrete_values_table_loader.sv
// Stream-to-table write adapter: parses {VAR, COUNT, (START, END)*} records from a word
// stream and emits one registered write per valid {start, end} range.
module discrete_values_table_loader #(
  parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
  parameter int unsigned MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
  localparam int unsigned W = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int unsigned V = MAX_BIT_WIDTH_OF_VARIABLES_INDEX,
  localparam int unsigned C = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES,
  localparam int unsigned A = V + C
) (
  input  logic           in_clock,
  input  logic           in_reset_n,
  input  logic           in_start,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           out_ready,
  output logic           out_write_enable,
  output logic [A-1:0]   out_write_address,
  output logic [2*W-1:0] out_write_data,
  output logic           out_busy,
  output logic           out_done,
  output logic           out_error,
  output logic [A:0]     out_entries_written
);

  typedef enum logic [2:0] {
    StIdle,
    StVar,
    StCount,
    StStart,
    StEnd
  } state_t;

  // Full table size; the write counter stops here.
  localparam logic [A:0] EntriesFull = {1'b1, {A{1'b0}}};
  localparam logic [A:0] EntriesOne  = {{A{1'b0}}, 1'b1};

  state_t         state;
  logic [V-1:0]   var_idx;
  logic [C-1:0]   choice_count;
  logic [C-1:0]   choice_idx;
  logic [W-1:0]   start_val;

  logic accept;
  logic range_ok;
  logic last_choice;

  assign out_ready   = (state != StIdle);
  assign accept      = in_valid && out_ready;
  assign range_ok    = (start_val <= in_data);
  assign last_choice = (choice_idx == choice_count);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state               <= StIdle;
      var_idx             <= '0;
      choice_count        <= '0;
      choice_idx          <= '0;
      start_val           <= '0;
      out_write_enable    <= 1'b0;
      out_write_address   <= '0;
      out_write_data      <= '0;
      out_busy            <= 1'b0;
      out_done            <= 1'b0;
      out_error           <= 1'b0;
      out_entries_written <= '0;
    end else begin
      out_write_enable <= 1'b0;
      out_done         <= 1'b0;
      case (state)
        StIdle: begin
          if (in_start) begin
            state               <= StVar;
            out_busy            <= 1'b1;
            out_error           <= 1'b0;
            out_entries_written <= '0;
          end
        end
        StVar: begin
          if (accept) begin
            var_idx <= in_data[V-1:0];
            if (in_last) begin
              state     <= StIdle;
              out_busy  <= 1'b0;
              out_error <= 1'b1;
            end else begin
              state <= StCount;
            end
          end
        end
        StCount: begin
          if (accept) begin
            choice_count <= in_data[C-1:0];
            choice_idx   <= '0;
            if (in_last) begin
              state     <= StIdle;
              out_busy  <= 1'b0;
              out_error <= 1'b1;
            end else begin
              state <= StStart;
            end
          end
        end
        StStart: begin
          if (accept) begin
            start_val <= in_data;
            if (in_last) begin
              state     <= StIdle;
              out_busy  <= 1'b0;
              out_error <= 1'b1;
            end else begin
              state <= StEnd;
            end
          end
        end
        StEnd: begin
          if (accept) begin
            // A valid range is written even when this word also ends the session early.
            if (range_ok) begin
              out_write_enable  <= 1'b1;
              out_write_address <= {var_idx, choice_idx};
              out_write_data    <= {start_val, in_data};
              if (out_entries_written != EntriesFull) begin
                out_entries_written <= out_entries_written + EntriesOne;
              end
            end else begin
              out_error <= 1'b1;
            end
            if (last_choice) begin
              if (in_last) begin
                state    <= StIdle;
                out_busy <= 1'b0;
                out_done <= 1'b1;
              end else begin
                state <= StVar;
              end
            end else begin
              choice_idx <= choice_idx + 1'b1;
              if (in_last) begin
                state     <= StIdle;
                out_busy  <= 1'b0;
                out_error <= 1'b1;
              end else begin
                state <= StStart;
              end
            end
          end
        end
        default: begin
          state    <= StIdle;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_discrete_values_table_loader.sv
// Directed bench for discrete_values_table_loader: a per-cycle vector table plus
// hand-written sequences for multi-record, gap, saturation, error and reset cases.
module tb_discrete_values_table_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready;
  logic        we;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [27:0] wr_q[$];
  logic [27:0] ref_q[$];
  int          done_cnt = 0;
  int          wide_cnt = 0;
  logic        we_prev = 1'b0;

  always #5 clk = ~clk;

  discrete_values_table_loader dut (
    .in_clock            (clk),
    .in_reset_n          (rst_n),
    .in_start            (start),
    .in_data             (data),
    .in_valid            (valid),
    .in_last             (last),
    .out_ready           (ready),
    .out_write_enable    (we),
    .out_write_address   (addr),
    .out_write_data      (wdata),
    .out_busy            (busy),
    .out_done            (done),
    .out_error           (err),
    .out_entries_written (cnt)
  );

  always @(negedge clk) begin
    if (we) begin
      wr_q.push_back({addr, wdata});
      if (we_prev) wide_cnt++;
    end
    if (done) done_cnt++;
    we_prev = we;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit st, input logic [7:0] d, input bit v, input bit l);
    start = st; data = d; valid = v; last = l;
    @(posedge clk);
    #1;
    start = 1'b0; valid = 1'b0; last = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int gap, input bit exp_rdy);
    repeat (gap) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ready_before_word", {31'b0, ready}, {31'b0, exp_rdy});
    cyc(1'b0, d, 1'b1, l);
  endtask

  typedef struct {
    bit          st;
    logic [7:0]  d;
    bit          v;
    bit          l;
    bit          we;
    logic [11:0] addr;
    logic [15:0] wd;
    bit          done;
    bit          err;
    logic [12:0] cnt;
    bit          busy;
    bit          rdy;
  } vec_t;

  vec_t vt[14];

  logic [7:0] rec4[10];

  task automatic run_rec4(input bit gaps);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send(rec4[i], i == 9, gaps ? int'($urandom_range(0, 3)) : 0, 1'b1);
    end
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Single record, then bad range, then early in_last on a VAR word.
    vt[0]  = '{1, 8'd0,  0, 0, 0, 12'h000, 16'h0000, 0, 0, 13'd0, 1, 1};
    vt[1]  = '{0, 8'd3,  1, 0, 0, 12'h000, 16'h0000, 0, 0, 13'd0, 1, 1};
    vt[2]  = '{0, 8'd0,  1, 0, 0, 12'h000, 16'h0000, 0, 0, 13'd0, 1, 1};
    vt[3]  = '{0, 8'd10, 1, 0, 0, 12'h000, 16'h0000, 0, 0, 13'd0, 1, 1};
    vt[4]  = '{0, 8'd20, 1, 1, 1, 12'h030, 16'h0A14, 1, 0, 13'd1, 0, 0};
    vt[5]  = '{0, 8'd0,  0, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd1, 0, 0};
    vt[6]  = '{1, 8'd0,  0, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd0, 1, 1};
    vt[7]  = '{0, 8'd2,  1, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd0, 1, 1};
    vt[8]  = '{0, 8'd0,  1, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd0, 1, 1};
    vt[9]  = '{0, 8'd30, 1, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd0, 1, 1};
    vt[10] = '{0, 8'd10, 1, 1, 0, 12'h030, 16'h0A14, 1, 1, 13'd0, 0, 0};
    vt[11] = '{0, 8'd0,  0, 0, 0, 12'h030, 16'h0A14, 0, 1, 13'd0, 0, 0};
    vt[12] = '{1, 8'd0,  0, 0, 0, 12'h030, 16'h0A14, 0, 0, 13'd0, 1, 1};
    vt[13] = '{0, 8'd5,  1, 1, 0, 12'h030, 16'h0A14, 0, 1, 13'd0, 0, 0};

    rec4 = '{8'd6, 8'd3, 8'd1, 8'd4, 8'd2, 8'd2, 8'd3, 8'd9, 8'd0, 8'd255};

    // Reset state
    #12;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_we", {31'b0, we}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_cnt", {19'b0, cnt}, 32'd0);
    chk("reset_addr_data", {4'b0, addr, wdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].st, vt[i].d, vt[i].v, vt[i].l);
      chk($sformatf("vec%0d_we", i), {31'b0, we}, {31'b0, vt[i].we});
      chk($sformatf("vec%0d_addr", i), {20'b0, addr}, {20'b0, vt[i].addr});
      chk($sformatf("vec%0d_wdata", i), {16'b0, wdata}, {16'b0, vt[i].wd});
      chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, vt[i].done});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d_cnt", i), {19'b0, cnt}, {19'b0, vt[i].cnt});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vt[i].busy});
      chk($sformatf("vec%0d_ready", i), {31'b0, ready}, {31'b0, vt[i].rdy});
    end

    // Two records: var 1 with two choices, var 255 with sixteen choices.
    wr_q.delete();
    done_cnt = 0;
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    send(8'd1, 0, 0, 1); send(8'd1, 0, 0, 1);
    send(8'd5, 0, 0, 1); send(8'd5, 0, 0, 1);
    send(8'd7, 0, 0, 1); send(8'd9, 0, 0, 1);
    send(8'd255, 0, 0, 1); send(8'd15, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 0, 0, 1);
      send(8'(i + 1), i == 15, 0, 1);
    end
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    ref_q.delete();
    ref_q.push_back({12'h010, 16'h0505});
    ref_q.push_back({12'h011, 16'h0709});
    for (int i = 0; i < 16; i++) ref_q.push_back({12'hFF0 + 12'(i), 8'(i), 8'(i + 1)});
    chk("two_rec_nwrites", wr_q.size(), 32'd18);
    for (int i = 0; i < 18 && i < wr_q.size(); i++) begin
      chk($sformatf("two_rec_write%0d", i), {4'b0, wr_q[i]}, {4'b0, ref_q[i]});
    end
    chk("two_rec_cnt", {19'b0, cnt}, 32'd18);
    chk("two_rec_done", done_cnt, 32'd1);
    chk("two_rec_err", {31'b0, err}, 32'd0);

    // Gap-free vs random-gap 4-choice record.
    wr_q.delete();
    wide_cnt = 0;
    run_rec4(1'b0);
    ref_q.delete();
    ref_q.push_back({12'h060, 16'h0104});
    ref_q.push_back({12'h061, 16'h0202});
    ref_q.push_back({12'h062, 16'h0309});
    ref_q.push_back({12'h063, 16'h00FF});
    chk("rec4_nwrites", wr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk($sformatf("rec4_write%0d", i), {4'b0, wr_q[i]}, {4'b0, ref_q[i]});
    end
    for (int rep = 0; rep < 3; rep++) begin
      wr_q.delete();
      run_rec4(1'b1);
      chk("rec4_gap_nwrites", wr_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
        chk($sformatf("rec4_gap_write%0d", i), {4'b0, wr_q[i]}, {4'b0, ref_q[i]});
      end
    end
    chk("strobe_width", wide_cnt, 32'd0);

    // Fill the whole table, then one more write: counter must saturate at 4096.
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int v = 0; v < 256; v++) begin
      send(8'(v), 0, 0, 1);
      send(8'd15, 0, 0, 1);
      for (int c = 0; c < 16; c++) begin
        send(8'(c), 0, 0, 1);
        send(8'(c), 0, 0, 1);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_cnt", {19'b0, cnt}, 32'd4096);
    done_cnt = 0;
    send(8'd0, 0, 0, 1); send(8'd0, 0, 0, 1);
    send(8'd0, 0, 0, 1); send(8'd0, 1, 0, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("sat_cnt", {19'b0, cnt}, 32'd4096);
    chk("sat_done", done_cnt, 32'd1);

    // Early in_last on a START word, then words offered while idle.
    wr_q.delete();
    done_cnt = 0;
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    send(8'd7, 0, 0, 1); send(8'd0, 0, 0, 1); send(8'd5, 1, 0, 1);
    chk("early_err", {31'b0, err}, 32'd1);
    chk("early_busy", {31'b0, busy}, 32'd0);
    chk("early_ready", {31'b0, ready}, 32'd0);
    for (int i = 0; i < 3; i++) send(8'd9, 0, 0, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("early_done", done_cnt, 32'd0);
    chk("early_nwrites", wr_q.size(), 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-record.
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    send(8'd9, 0, 0, 1); send(8'd0, 0, 0, 1); send(8'd8, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    chk("arst_addr_data", {4'b0, addr, wdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd20, 0, 0, 0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("arst_nwrites", wr_q.size(), 32'd0);

    // Fresh session after reset with an ignored mid-session in_start.
    done_cnt = 0;
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    send(8'd4, 0, 0, 1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    send(8'd0, 0, 0, 1); send(8'd1, 0, 0, 1); send(8'd2, 1, 0, 1);
    chk("post_we", {31'b0, we}, 32'd1);
    chk("post_addr", {20'b0, addr}, 32'h040);
    chk("post_wdata", {16'b0, wdata}, 32'h0102);
    chk("post_cnt", {19'b0, cnt}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_done", done_cnt, 32'd1);
    chk("post_nwrites", wr_q.size(), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
